// File: rtl/apb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_pkg
// Purpose  : Shared FSM encodings, default widths and USRT register map.
// Revision : 1.0 - initial release
// ============================================================================
package apb_master_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 8;

   localparam logic [31:0] REG_TX     = 32'h0000_0000;
   localparam logic [31:0] REG_RX     = 32'h0000_0004;
   localparam logic [31:0] REG_STATUS = 32'h0000_0008;

   function automatic logic is_bus_active(input logic [1:0] st);
      return (st == ST_SETUP) || (st == ST_ACCESS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_if
// Purpose  : Command/response handshake and APB bus signals of apb_master.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_if
   import apb_master_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) ();

   logic              i_Cmd_Valid;
   logic              o_Cmd_Ready;
   logic [ADDR_W-1:0] i_Cmd_Addr;
   logic              i_Cmd_Write;
   logic [DATA_W-1:0] i_Cmd_Wdata;
   logic              o_Rsp_Valid;
   logic [DATA_W-1:0] o_Rsp_Rdata;
   logic              o_Rsp_Err;
   logic [ADDR_W-1:0] o_Paddr;
   logic              o_Psel;
   logic              o_Penable;
   logic              o_Pwrite;
   logic [DATA_W-1:0] o_Pwdata;
   logic              i_Pready;
   logic [DATA_W-1:0] i_Prdata;

   modport master (
      input  i_Cmd_Valid, i_Cmd_Addr, i_Cmd_Write, i_Cmd_Wdata, i_Pready, i_Prdata,
      output o_Cmd_Ready, o_Rsp_Valid, o_Rsp_Rdata, o_Rsp_Err,
      output o_Paddr, o_Psel, o_Penable, o_Pwrite, o_Pwdata
   );

   // Host sequencer and APB slave side combined.
   modport slave (
      output i_Cmd_Valid, i_Cmd_Addr, i_Cmd_Write, i_Cmd_Wdata, i_Pready, i_Prdata,
      input  o_Cmd_Ready, o_Rsp_Valid, o_Rsp_Rdata, o_Rsp_Err,
      input  o_Paddr, o_Psel, o_Penable, o_Pwrite, o_Pwdata
   );

endinterface
`default_nettype wire

// File: rtl/apb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout
// Purpose  : Wait-cycle counter; o_Expired flags the cycle the limit is hit.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  wire logic i_Pclk,
   input  wire logic i_Presetn,
   input  wire logic i_Clear,
   input  wire logic i_Enable,
   output logic      o_Expired
);

   localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge i_Pclk or negedge i_Presetn) begin
      if (!i_Presetn) begin
         r_cnt <= '0;
      end else if (i_Clear) begin
         r_cnt <= '0;
      end else if (i_Enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Expires on the increment that brings the count to TIMEOUT_CYCLES.
   assign o_Expired = i_Enable && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-command APB initiator (SETUP/ACCESS) for the USRT slave.
//            Define APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master
   import apb_master_pkg::*;
#(
   parameter int          ADDR_W         = APB_ADDR_W,
   parameter int          DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  wire logic    i_Pclk,
   input  wire logic    i_Presetn,
   apb_master_if.master bus
);

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [ADDR_W-1:0] r_paddr;
   logic              r_pwrite;
   logic [DATA_W-1:0] r_pwdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_accept;
   logic              w_done;
   logic              w_expired;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign w_accept = (r_state == ST_IDLE) && bus.i_Cmd_Valid;
   assign w_done   = (r_state == ST_ACCESS) && (bus.i_Pready || w_expired);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (bus.i_Cmd_Valid) w_next = ST_SETUP;
         ST_SETUP:  w_next = ST_ACCESS;
         ST_ACCESS: if (w_done) w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Pclk or negedge i_Presetn) begin
      if (!i_Presetn) begin
         r_state  <= ST_IDLE;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_rdata  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_paddr  <= bus.i_Cmd_Addr;
            r_pwrite <= bus.i_Cmd_Write;
            r_pwdata <= bus.i_Cmd_Wdata;
         end
         // PREADY wins over a same-cycle expiry; writes and aborts return 0.
         if (w_done) begin
            r_rdata <= (bus.i_Pready && !r_pwrite) ? bus.i_Prdata : '0;
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   logic r_err;

   apb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_Pclk    (i_Pclk),
      .i_Presetn (i_Presetn),
      .i_Clear   (r_state != ST_ACCESS),
      .i_Enable  ((r_state == ST_ACCESS) && !bus.i_Pready),
      .o_Expired (w_expired)
   );

   always_ff @(posedge i_Pclk or negedge i_Presetn) begin
      if (!i_Presetn) begin
         r_err <= 1'b0;
      end else if (w_done) begin
         r_err <= !bus.i_Pready;
      end
   end

   assign bus.o_Rsp_Err = r_err;
`else
   assign w_expired     = 1'b0;
   assign bus.o_Rsp_Err = 1'b0;
`endif

   assign bus.o_Cmd_Ready = (r_state == ST_IDLE);
   assign bus.o_Rsp_Valid = (r_state == ST_RESP);
   assign bus.o_Rsp_Rdata = r_rdata;
   assign bus.o_Psel      = is_bus_active(r_state);
   assign bus.o_Penable   = (r_state == ST_ACCESS);
   assign bus.o_Paddr     = r_paddr;
   assign bus.o_Pwrite    = r_pwrite;
   assign bus.o_Pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Directed self-checking bench for apb_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;
   import apb_master_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   apb_master_if #(.ADDR_W(32), .DATA_W(8)) bus ();

   apb_master #(
      .ADDR_W         (32),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_Pclk    (clk),
      .i_Presetn (rst_n),
      .bus       (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and act as the APB slave; waits < 0 means never ready.
   task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [7:0] wd,
                          input int waits, input logic [7:0] prd,
                          output int lat, output int n_sel, output int n_en,
                          output logic [7:0] rd, output logic err, output logic stable);
      int acc;
      logic done;
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Addr  = addr;
      bus.i_Cmd_Write = wr;
      bus.i_Cmd_Wdata = wd;
      bus.i_Pready    = 1'b0;
      tick();
      bus.i_Cmd_Valid = 1'b0;
      lat = 1; acc = 0; n_sel = 0; n_en = 0; done = 1'b0;
      rd = 8'hxx; err = 1'bx; stable = 1'b1;
      while (!done && lat < 64) begin
         if (bus.o_Psel) begin
            n_sel++;
            if (bus.o_Paddr !== addr || bus.o_Pwrite !== wr || (wr && bus.o_Pwdata !== wd))
               stable = 1'b0;
         end
         if (bus.o_Penable) n_en++;
         if (bus.o_Rsp_Valid) begin
            done = 1'b1;
            rd   = bus.o_Rsp_Rdata;
            err  = bus.o_Rsp_Err;
         end else begin
            if (bus.o_Psel && bus.o_Penable) begin
               bus.i_Pready = (acc == waits);
               bus.i_Prdata = (acc == waits) ? prd : 8'hEE;
               acc++;
            end else begin
               bus.i_Pready = 1'b0;
            end
            tick();
            lat++;
         end
      end
      bus.i_Pready = 1'b0;
      if (!done) check_eq("rsp_seen", 32'd0, 32'd1);
   endtask

   initial begin
      int lat, n_sel, n_en, rsp_cnt, phase, gap, acc_cnt, acc_idx;
      logic [7:0] rd;
      logic err, stable;

      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n_sel, n_en, rsp_cnt, phase, gap, acc_cnt, acc_idx;
      logic [7:0] rd;
      logic err, stable;

      rst_n = 1'b0;
      bus.i_Cmd_Valid = 1'b0;
      bus.i_Cmd_Addr  = '0;
      bus.i_Cmd_Write = 1'b0;
      bus.i_Cmd_Wdata = '0;
      bus.i_Pready    = 1'b0;
      bus.i_Prdata    = '0;
      #3;
      check_eq("rst_ready", {31'd0, bus.o_Cmd_Ready}, 32'd1);
      check_eq("rst_ctrl", {28'd0, bus.o_Psel, bus.o_Penable, bus.o_Pwrite, bus.o_Rsp_Valid}, 32'd0);
      check_eq("rst_paddr", bus.o_Paddr, 32'd0);
      check_eq("rst_data", {15'd0, bus.o_Rsp_Err, bus.o_Pwdata, bus.o_Rsp_Rdata}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Write TX, zero wait states.
      do_xfer(REG_TX, 1'b1, 8'hA5, 0, 8'h00, lat, n_sel, n_en, rd, err, stable);
      check_eq("t1_lat", lat, 32'd3);
      check_eq("t1_psel_cycles", n_sel, 32'd2);
      check_eq("t1_pen_cycles", n_en, 32'd1);
      check_eq("t1_stable", {31'd0, stable}, 32'd1);
      check_eq("t1_err", {31'd0, err}, 32'd0);
      check_eq("t1_rdata", {24'd0, rd}, 32'd0);
      tick();
      check_eq("t1_ready_after", {31'd0, bus.o_Cmd_Ready}, 32'd1);
      check_eq("t1_pwdata_held", {24'd0, bus.o_Pwdata}, 32'hA5);

      // Read RX with three wait states.
      do_xfer(REG_RX, 1'b0, 8'h00, 3, 8'h3C, lat, n_sel, n_en, rd, err, stable);
      check_eq("t2_lat", lat, 32'd6);
      check_eq("t2_pen_cycles", n_en, 32'd4);
      check_eq("t2_stable", {31'd0, stable}, 32'd1);
      check_eq("t2_rdata", {24'd0, rd}, 32'h3C);
      check_eq("t2_err", {31'd0, err}, 32'd0);
      tick(); tick(); tick();
      check_eq("t2_rdata_held", {24'd0, bus.o_Rsp_Rdata}, 32'h3C);

      // Back-to-back reads with valid held high and PREADY always 1.
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Write = 1'b0;
      bus.i_Cmd_Addr  = REG_STATUS;
      bus.i_Pready    = 1'b1;
      bus.i_Prdata    = 8'h42;
      rsp_cnt = 0; phase = 0; gap = 0; acc_cnt = 0; acc_idx = -1;
      for (int c = 0; c < 10; c++) begin
         if (bus.i_Cmd_Valid && bus.o_Cmd_Ready) begin
            acc_cnt++;
            if (acc_cnt == 2) acc_idx = c;
         end
         if (bus.o_Rsp_Valid) rsp_cnt++;
         case (phase)
            0: if (bus.o_Psel) phase = 1;
            1: if (!bus.o_Psel) begin phase = 2; gap = 1; end
            2: if (bus.o_Psel) phase = 3; else gap++;
            default: ;
         endcase
         tick();
         if (acc_cnt == 2) bus.i_Cmd_Valid = 1'b0;
      end
      bus.i_Pready = 1'b0;
      check_eq("t3_second_accept", acc_idx, 32'd4);
      check_eq("t3_rsp_count", rsp_cnt, 32'd2);
      check_eq("t3_second_xfer", phase, 32'd3);
      check_eq("t3_psel_gap_min", {31'd0, gap >= 1}, 32'd1);
      check_eq("t3_rdata", {24'd0, bus.o_Rsp_Rdata}, 32'h42);

`ifdef APB_MASTER_TIMEOUT_EN
      // Slave never ready: abort after 16 ACCESS cycles.
      do_xfer(REG_RX, 1'b0, 8'h00, -1, 8'h00, lat, n_sel, n_en, rd, err, stable);
      check_eq("t4_lat", lat, 32'd18);
      check_eq("t4_pen_cycles", n_en, 32'd16);
      check_eq("t4_err", {31'd0, err}, 32'd1);
      check_eq("t4_rdata", {24'd0, rd}, 32'd0);
      check_eq("t4_psel_at_rsp", {31'd0, bus.o_Psel}, 32'd0);
`else
      // No timeout: a 40-wait-state access must simply keep waiting.
      do_xfer(REG_RX, 1'b0, 8'h00, 40, 8'h5A, lat, n_sel, n_en, rd, err, stable);
      check_eq("t4_lat", lat, 32'd43);
      check_eq("t4_pen_cycles", n_en, 32'd41);
      check_eq("t4_err", {31'd0, err}, 32'd0);
      check_eq("t4_rdata", {24'd0, rd}, 32'h5A);
`endif
      tick();
      check_eq("t4_ready_after", {31'd0, bus.o_Cmd_Ready}, 32'd1);

      // Reset in the middle of ACCESS.
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Write = 1'b1;
      bus.i_Cmd_Addr  = REG_TX;
      bus.i_Cmd_Wdata = 8'h77;
      tick();
      bus.i_Cmd_Valid = 1'b0;
      tick();
      check_eq("t5_in_access", {31'd0, bus.o_Penable}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_ctrl_async", {29'd0, bus.o_Psel, bus.o_Penable, bus.o_Pwrite}, 32'd0);
      check_eq("t5_bus_async", {bus.o_Paddr[23:0], bus.o_Pwdata}, 32'd0);
      rsp_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.o_Rsp_Valid) rsp_cnt++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (bus.o_Rsp_Valid) rsp_cnt++;
         tick();
      end
      check_eq("t5_no_rsp", rsp_cnt, 32'd0);
      do_xfer(REG_RX, 1'b0, 8'h00, 0, 8'h99, lat, n_sel, n_en, rd, err, stable);
      check_eq("t5_after_lat", lat, 32'd3);
      check_eq("t5_after_rdata", {24'd0, rd}, 32'h99);
      tick();

      // PREADY pulses in IDLE and in SETUP are ignored.
      rsp_cnt = 0;
      bus.i_Pready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.o_Rsp_Valid || bus.o_Psel) rsp_cnt++;
      end
      check_eq("t6_idle_ignored", rsp_cnt, 32'd0);
      check_eq("t6_idle_ready", {31'd0, bus.o_Cmd_Ready}, 32'd1);
      bus.i_Pready    = 1'b0;
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Write = 1'b0;
      bus.i_Cmd_Addr  = REG_RX;
      tick();
      bus.i_Cmd_Valid = 1'b0;
      bus.i_Pready    = 1'b1;
      bus.i_Prdata    = 8'h11;
      tick();
      bus.i_Pready = 1'b0;
      check_eq("t6_setup_to_access", {30'd0, bus.o_Penable, bus.o_Rsp_Valid}, 32'd2);
      tick();
      check_eq("t6_still_access", {30'd0, bus.o_Penable, bus.o_Rsp_Valid}, 32'd2);
      bus.i_Pready = 1'b1;
      bus.i_Prdata = 8'h6B;
      tick();
      bus.i_Pready = 1'b0;
      check_eq("t6_rsp", {23'd0, bus.o_Rsp_Valid, bus.o_Rsp_Rdata}, 32'h16B);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
